// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants and types
// for the parametrised VGA timing generator.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_CW       = 11;
  localparam int VGA_MAX_DLY  = 8;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } timing_t;

  function automatic int vga_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the
// generator (master) to the colour pipeline (slave).
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int CW = VGA_CW
);

  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic          de;

  modport master (
    output x, y, line_start, frame_start,
    output hsync, vsync, de
  );

  modport slave (
    input x, y, line_start, frame_start,
    input hsync, vsync, de
  );

endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: enabled shift register, flushed to
// zero on reset; depth 0 is a plain wire.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int W     = $bits(timing_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH < 0 || DEPTH > VGA_MAX_DLY) begin : g_bad
    $error("vga_delay_line: DEPTH out of range");
  end

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, en};
    assign dout = din;
  end else begin : g_sr
    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    // shift one place per enabled clock
    always_comb begin
      sr_d = sr_q;
      if (en) begin
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end
    end

    // stage registers, flushed to inactive on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          sr_q[i] <= '0;
        end
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster counters with
// sync/DE decode and an alignment delay line.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CW         = VGA_CW,
  parameter int PIPE_DLY   = 0
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic en,
  vga_timing_gen_if.master tim
);

  localparam int H_TOTAL =
    vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (longint'(H_TOTAL) > (longint'(1) << CW) ||
      longint'(V_TOTAL) > (longint'(1) << CW))
  begin : g_bad_cw
    $error("vga_timing_gen: totals exceed counter");
  end

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 ||
      H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 ||
      V_SYNC < 1 || V_BP < 1)
  begin : g_bad_width
    $error("vga_timing_gen: zero timing width");
  end

  if (PIPE_DLY < 0 || PIPE_DLY > VGA_MAX_DLY)
  begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY out of range");
  end

  localparam logic [CW-1:0] H_LAST =
    CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST =
    CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG =
    CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END =
    CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG =
    CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END =
    CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  timing_t       raw;
  timing_t       dly;
  logic          ls;

  // advance h every enabled clock; v steps on h wrap
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // counter registers; reset wins over en
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // undelayed decode, held inactive during reset
  always_comb begin
    raw = '0;
    if (!reset) begin
      raw.de = (h_q < H_ACT) && (v_q < V_ACT);
      raw.hs = (h_q >= HS_BEG) && (h_q < HS_END);
      raw.vs = (v_q >= VS_BEG) && (v_q < VS_END);
    end
  end

  vga_delay_line #(
    .DEPTH (PIPE_DLY),
    .W     ($bits(timing_t))
  ) u_dly (
    .clk  (clk_pixel),
    .rst  (reset),
    .en   (en),
    .din  (raw),
    .dout (dly)
  );

  assign ls = en && !reset && (h_q == '0);

  assign tim.x           = h_q;
  assign tim.y           = v_q;
  assign tim.line_start  = ls;
  assign tim.frame_start = ls && (v_q == '0);
  assign tim.de          = dly.de;
  assign tim.hsync =
    (H_SYNC_POL != 0) ? dly.hs : !dly.hs;
  assign tim.vsync =
    (V_SYNC_POL != 0) ? dly.vs : !dly.vs;

endmodule
